// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment hex display controller: shadow-captures a packed hex word on load,
// decodes nibbles with dp, leading-zero blanking and blink; drives static and scanned outputs.
module hex_display_ctrl #(
    parameter int DIGITS      = 6,
    parameter int CLK_HZ      = 50_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int SCAN_HZ     = 1000,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  blank_lz,
    input  logic                  disp_en,
    output logic [7*DIGITS-1:0]   hex,
    output logic [DIGITS-1:0]     hex_dp,
    output logic [7:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_an
);

    localparam int BLINK_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_DIV = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
    localparam int SCAN_RAW  = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int SCAN_DIV  = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
    localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // XOR masks: an active-high pattern XOR mask gives pin polarity; the mask alone is OFF.
    localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [4*DIGITS-1:0]     r_value;
    logic [DIGITS-1:0]       r_dp;
    logic [DIGITS-1:0]       r_blink;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_hidden;
    logic [SW-1:0]           r_scan_cnt;
    logic [IW-1:0]           r_scan_idx;
    logic                    r_scan_gap;
    logic [7*DIGITS-1:0]     r_hex;
    logic [DIGITS-1:0]       r_hex_dp;
    logic [7:0]              r_scan_seg;
    logic [DIGITS-1:0]       r_scan_an;

    logic [DIGITS-1:0]       w_lz;
    logic [DIGITS-1:0]       w_dark;
    logic [DIGITS-1:0][7:0]  w_pat;
    logic [7*DIGITS-1:0]     w_hex;
    logic [DIGITS-1:0]       w_hex_dp;
    logic [7:0]              w_sel_pat;
    logic [DIGITS-1:0]       w_onehot;
    logic [7:0]              w_scan_seg;
    logic [DIGITS-1:0]       w_scan_an;
    logic                    w_blink_wrap;
    logic                    w_scan_wrap;
    logic [IW-1:0]           w_idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_dp    <= '0;
            r_blink <= '0;
        end else if (load) begin
            r_value <= value;
            r_dp    <= dp_in;
            r_blink <= blink_en;
        end
    end

    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_hidden    <= 1'b0;
        end else if (w_blink_wrap) begin
            r_blink_cnt <= '0;
            r_hidden    <= !r_hidden;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Leading zero: this nibble and every nibble above it are zero; digit 0 always shows.
    always_comb begin
        logic w_upper_zero;
        w_upper_zero = 1'b1;
        w_lz         = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (r_value[4*i +: 4] == 4'h0);
            w_lz[i]      = (i > 0) && w_upper_zero;
        end
    end

    always_comb begin
        w_dark   = '0;
        w_pat    = '0;
        w_hex    = '0;
        w_hex_dp = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dark[i]       = !disp_en || (r_blink[i] && r_hidden) || (blank_lz && w_lz[i]);
            w_pat[i]        = w_dark[i] ? 8'h00 : {r_dp[i], seg_decode(r_value[4*i +: 4])};
            w_hex[7*i +: 7] = w_pat[i][6:0] ^ SEG_OFF;
            w_hex_dp[i]     = w_pat[i][7] ^ DP_OFF;
        end
    end

    // The divider pauses during the anti-ghost gap so each digit keeps its full dwell time.
    assign w_scan_wrap = !r_scan_gap && (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_idx_next  = (r_scan_idx == IW'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_scan_gap <= 1'b0;
        end else if (r_scan_gap) begin
            r_scan_gap <= 1'b0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_scan_idx <= w_idx_next;
            r_scan_gap <= 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_sel_pat  = w_pat[r_scan_idx];
    assign w_onehot   = DIGITS'(1) << r_scan_idx;
    assign w_scan_seg = r_scan_gap ? {DP_OFF, SEG_OFF} : (w_sel_pat ^ {DP_OFF, SEG_OFF});
    assign w_scan_an  = r_scan_gap ? AN_OFF : (w_onehot ^ AN_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex      <= {DIGITS{SEG_OFF}};
            r_hex_dp   <= {DIGITS{DP_OFF}};
            r_scan_seg <= {DP_OFF, SEG_OFF};
            r_scan_an  <= AN_OFF;
        end else begin
            r_hex      <= w_hex;
            r_hex_dp   <= w_hex_dp;
            r_scan_seg <= w_scan_seg;
            r_scan_an  <= w_scan_an;
        end
    end

    assign hex      = r_hex;
    assign hex_dp   = r_hex_dp;
    assign scan_seg = r_scan_seg;
    assign scan_an  = r_scan_an;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed cases plus random traffic against a
// cycle-count based reference model of decode, blanking, blink and scan sequencing.
module tb_hex_display_ctrl;

    localparam int DIGITS   = 6;
    localparam int CLK_HZ   = 1000;
    localparam int BLINK_HZ = 50;
    localparam int SCAN_HZ  = 100;
    localparam int BDIV     = CLK_HZ / (2 * BLINK_HZ);
    localparam int SDIV_RAW = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int SDIV     = (SDIV_RAW < 1) ? 1 : SDIV_RAW;

    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [23:0] value;
    logic [5:0]  dp_in;
    logic [5:0]  blink_en;
    logic        blank_lz;
    logic        disp_en;
    logic [41:0] hex;
    logic [5:0]  hex_dp;
    logic [7:0]  scan_seg;
    logic [5:0]  scan_an;

    logic [23:0] m_val;
    logic [5:0]  m_dp;
    logic [5:0]  m_blk;
    int          m_n;
    logic [41:0] e_hex;
    logic [5:0]  e_dp;
    logic [5:0]  e_an;
    logic [7:0]  e_seg;
    bit          e_gap;
    int          n_chk;
    int          n_fail;

    hex_display_ctrl #(
        .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .SCAN_HZ(SCAN_HZ),
        .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blink_en(blink_en), .blank_lz(blank_lz), .disp_en(disp_en), .hex(hex),
        .hex_dp(hex_dp), .scan_seg(scan_seg), .scan_an(scan_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after the coming edge, from state after m_n edges since reset.
    task automatic model_eval();
        logic [7:0] pat [DIGITS];
        bit         hidden;
        int         p;
        int         idx;
        hidden = ((m_n / BDIV) % 2) == 1;
        for (int i = 0; i < DIGITS; i++) begin
            logic [3:0] nib;
            bit         lz;
            bit         dark;
            nib  = 4'(m_val >> (4 * i));
            lz   = (i > 0) && ((m_val >> (4 * i)) == 24'h0);
            dark = !disp_en || (m_blk[i] && hidden) || (blank_lz && lz);
            pat[i] = dark ? 8'h00 : {m_dp[i], SEG_TAB[nib]};
            e_hex[7*i +: 7] = ~pat[i][6:0];
            e_dp[i]         = ~pat[i][7];
        end
        p     = m_n % (SDIV + 1);
        e_gap = (p == SDIV);
        idx   = (m_n / (SDIV + 1)) % DIGITS;
        e_an  = e_gap ? 6'h3F : ~(6'b000001 << idx);
        e_seg = ~pat[idx];
    endtask

    task automatic tick();
        @(posedge clk);
        model_eval();
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
            m_blk = blink_en;
        end
        m_n++;
        @(negedge clk);
        chk("hex", 64'(hex), 64'(e_hex));
        chk("hex_dp", 64'(hex_dp), 64'(e_dp));
        chk("scan_an", 64'(scan_an), 64'(e_an));
        if (!e_gap) chk("scan_seg", 64'(scan_seg), 64'(e_seg));
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_hex", 64'(hex), 64'({42{1'b1}}));
        chk("rst_hex_dp", 64'(hex_dp), 64'(6'h3F));
        chk("rst_scan_seg", 64'(scan_seg), 64'(8'hFF));
        chk("rst_scan_an", 64'(scan_an), 64'(6'h3F));
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        m_val = '0;
        m_dp  = '0;
        m_blk = '0;
        m_n   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] walk [13];
        int         sh;
        walk = '{6'h3E, 6'h3F, 6'h3D, 6'h3F, 6'h3B, 6'h3F, 6'h37, 6'h3F, 6'h2F, 6'h3F, 6'h1F, 6'h3F, 6'h3E};
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blink_en = '0;
        blank_lz = 1'b0;
        disp_en  = 1'b1;
        m_val    = '0;
        m_dp     = '0;
        m_blk    = '0;
        m_n      = 0;

        apply_reset();

        // Scan walk right after reset: one gap cycle between every digit step.
        for (int k = 0; k < 13; k++) begin
            tick();
            chk("scan_walk", 64'(scan_an), 64'(walk[k]));
        end

        // Plain decode, then leading-zero blanking, then an all-zero value.
        value = 24'h00A5F3;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("dec_a5f3", 64'(hex), 64'({7'h40, 7'h40, 7'h08, 7'h12, 7'h0E, 7'h30}));
        blank_lz = 1'b1;
        tick();
        chk("lz_a5f3", 64'(hex), 64'({7'h7F, 7'h7F, 7'h08, 7'h12, 7'h0E, 7'h30}));
        value = 24'h000000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("lz_zero", 64'(hex), 64'({{5{7'h7F}}, 7'h40}));

        // Blink on digit 0 with its decimal point.
        value    = 24'h123456;
        dp_in    = 6'b000001;
        blink_en = 6'b000001;
        blank_lz = 1'b0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 45; k++) tick();

        // Display disabled while loading, then re-enabled.
        dp_in    = '0;
        blink_en = '0;
        disp_en  = 1'b0;
        value    = 24'h000012;
        load     = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("dis_dark", 64'(hex), 64'({42{1'b1}}));
        chk("dis_dark_dp", 64'(hex_dp), 64'(6'h3F));
        disp_en = 1'b1;
        tick();
        chk("dis_reen", 64'(hex), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24}));

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) apply_reset();
            sh       = int'($urandom_range(0, 6));
            load     = ($urandom_range(0, 3) == 0);
            value    = 24'($urandom) >> (4 * sh);
            dp_in    = 6'($urandom);
            blink_en = 6'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
            disp_en  = ($urandom_range(0, 9) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
